// File: rtl/cdb_rob_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_rob_arbiter
// Description : Round-robin arbiter sharing the single ROB writeback port among
//               functional units, with a registered one-cycle writeback stage.
// Revision    : 1.0
// ============================================================================
module cdb_rob_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ENTRY_W = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ENTRY_W-1:0]   req_entry,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         flush,
  output logic                         rob_data_ready,
  output logic                         rob_commit_ready,
  output logic [ENTRY_W-1:0]           rob_data_entry,
  output logic [DATA_W-1:0]            rob_data_out,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   idx;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  logic               transfer;

  logic [ENTRY_W-1:0] entry_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr  [NUM_REQ];

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign entry_arr[i] = req_entry[i*ENTRY_W +: ENTRY_W];
      assign data_arr[i]  = req_data[i*DATA_W +: DATA_W];
    end
  endgenerate

  // Search starts at rr_ptr and wraps; pointer width makes the wrap implicit.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr + PTR_W'(k);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        win        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  assign req_ready = (rst_n && !flush) ? grant : '0;
  assign transfer  = |req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rob_data_ready   <= 1'b0;
      rob_commit_ready <= 1'b0;
      rob_data_entry   <= '0;
      rob_data_out     <= '0;
      grant_id         <= '0;
      rr_ptr           <= '0;
    end else begin
      rob_data_ready   <= transfer;
      rob_commit_ready <= transfer;
      if (transfer) begin
        rob_data_entry <= entry_arr[win];
        rob_data_out   <= data_arr[win];
        grant_id       <= win;
        rr_ptr         <= win + PTR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_rob_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_rob_arbiter
// Description : Directed self-checking bench for cdb_rob_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_cdb_rob_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [11:0]  req_entry;
  logic [255:0] req_data;
  logic [3:0]   req_ready;
  logic         flush;
  logic         rob_data_ready;
  logic         rob_commit_ready;
  logic [2:0]   rob_data_entry;
  logic [63:0]  rob_data_out;
  logic [1:0]   grant_id;

  int n_checks = 0;
  int n_errors = 0;

  cdb_rob_arbiter #(.NUM_REQ(4), .DATA_W(64), .ENTRY_W(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_entry        (req_entry),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .flush            (flush),
    .rob_data_ready   (rob_data_ready),
    .rob_commit_ready (rob_commit_ready),
    .rob_data_entry   (rob_data_entry),
    .rob_data_out     (rob_data_out),
    .grant_id         (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] e, input logic [63:0] d);
    req_entry[i*3 +: 3]  = e;
    req_data[i*64 +: 64] = d;
  endtask

  // Registered-stage expectations, checked #1 after the active edge.
  task automatic check_out(input string tag, input logic strobe, input logic [2:0] e,
                           input logic [63:0] d, input logic [1:0] g);
    check({tag, ".data_ready"},   rob_data_ready,   strobe);
    check({tag, ".commit_ready"}, rob_commit_ready, strobe);
    check({tag, ".entry"},        rob_data_entry,   e);
    check({tag, ".data"},         rob_data_out,     d);
    check({tag, ".grant_id"},     grant_id,         g);
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic f, input logic r);
    @(negedge clk);
    req_valid = v;
    flush     = f;
    rst_n     = r;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 4'b1111;
    req_entry = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 2), 64'h1000 + 64'(i));
    #1;
    check("reset.ready_blocked", req_ready, 4'b0000);
    edge_wait();
    edge_wait();
    check_out("reset", 1'b0, 3'd0, 64'h0, 2'd0);

    // Single request from requester 0
    set_req(0, 3'd5, 64'hA5);
    drive(4'b0001, 1'b0, 1'b1);
    check("single.ready", req_ready, 4'b0001);
    edge_wait();
    check_out("single", 1'b1, 3'd5, 64'hA5, 2'd0);

    // Re-reset so round-robin starts at 0
    set_req(0, 3'd2, 64'h1000);
    drive(4'b0000, 1'b0, 1'b0);
    edge_wait();
    drive(4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) drive(4'b1111, 1'b0, 1'b1);
      check($sformatf("rr%0d.ready", i), req_ready, 4'b0001 << i);
      edge_wait();
      check_out($sformatf("rr%0d", i), 1'b1, 3'(i + 2), 64'h1000 + 64'(i), 2'(i));
    end

    // Idle cycle: strobes drop, payload holds
    drive(4'b0000, 1'b0, 1'b1);
    check("idle.ready", req_ready, 4'b0000);
    edge_wait();
    check_out("idle", 1'b0, 3'd5, 64'h1003, 2'd3);

    // Move pointer to 2, then 0011 must grant 0 first, then 1
    drive(4'b0010, 1'b0, 1'b1);
    check("ptr2.ready", req_ready, 4'b0010);
    edge_wait();
    drive(4'b0011, 1'b0, 1'b1);
    check("wrap.ready0", req_ready, 4'b0001);
    edge_wait();
    check("wrap.gid0", grant_id, 2'd0);
    drive(4'b0011, 1'b0, 1'b1);
    check("wrap.ready1", req_ready, 4'b0010);
    edge_wait();
    check("wrap.gid1", grant_id, 2'd1);

    // Flush blocks grant, pointer stays at 2
    drive(4'b0110, 1'b1, 1'b1);
    check("flush.ready", req_ready, 4'b0000);
    check("flush.prev_strobe_kept", rob_data_ready, 1'b1);
    edge_wait();
    check_out("flush", 1'b0, 3'd3, 64'h1001, 2'd1);
    drive(4'b0110, 1'b0, 1'b1);
    check("post_flush.ready", req_ready, 4'b0100);
    edge_wait();
    check_out("post_flush", 1'b1, 3'd4, 64'h1002, 2'd2);

    // Transfer in N, flush in N+1
    drive(4'b1000, 1'b0, 1'b1);
    check("xfer.ready", req_ready, 4'b1000);
    edge_wait();
    drive(4'b0000, 1'b1, 1'b1);
    check("xfer_flush.strobe_kept", rob_commit_ready, 1'b1);
    edge_wait();
    check("xfer_flush.strobe_drop", rob_data_ready, 1'b0);
    check("xfer_flush.commit_drop", rob_commit_ready, 1'b0);

    // Reset mid-stream
    drive(4'b1111, 1'b0, 1'b1);
    check("stream.ready0", req_ready, 4'b0001);
    edge_wait();
    drive(4'b1111, 1'b0, 1'b1);
    check("stream.ready1", req_ready, 4'b0010);
    drive(4'b1111, 1'b0, 1'b0);
    check("midrst.ready", req_ready, 4'b0000);
    edge_wait();
    check_out("midrst", 1'b0, 3'd0, 64'h0, 2'd0);
    drive(4'b1111, 1'b0, 1'b1);
    check("restart.ready", req_ready, 4'b0001);
    edge_wait();
    check_out("restart", 1'b1, 3'd2, 64'h1000, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_rob_arbiter.md
CDB_ROB_ARBITER -- requirements
Module: cdb_rob_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of functional-unit requesters; fixed at 4 for this revision.
REQ-002 Parameter DATA_W, 64, result width; matches ROB value field [63:0].
REQ-003 Parameter ENTRY_W, 3, ROB entry index width (8-entry ROB).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  4  bit i = requester i holds a finished result.
REQ-007 req_entry  input  12  requester i ROB index at bits [3i+2:3i].
REQ-008 req_data  input  256  requester i result at bits [64i+63:64i].
REQ-009 req_ready  output  4  one-hot-or-zero grant; bit i = requester i's result is accepted this cycle.
REQ-010 flush  input  1  mispredict; discard all in-flight writebacks.
REQ-011 rob_data_ready  output  1  registered strobe to ROB data_ready.
REQ-012 rob_commit_ready  output  1  registered strobe to ROB commit_ready.
REQ-013 rob_data_entry  output  3  registered ROB index to ROB data_entry.
REQ-014 rob_data_out  output  64  registered result to ROB Data_in.
REQ-015 grant_id  output  2  registered index of the requester driving the current strobe.

Function
REQ-016 The block shall share the single ROB writeback port among 4 requesters, with at most one transfer per cycle.
REQ-017 A transfer on requester i shall occur in the cycle where req_valid[i] and req_ready[i] are both 1.
REQ-018 req_ready shall be combinational from req_valid, rr_ptr, flush and rst_n.
REQ-019 Arbitration shall be round-robin: the winner is the first valid requester at or after rr_ptr, searching rr_ptr, rr_ptr+1, ... mod 4.
REQ-020 After a transfer by requester w, rr_ptr shall become (w+1) mod 4; with no transfer, rr_ptr shall hold.
REQ-021 req_ready shall be 0 on all bits when req_valid is 0, flush is 1, or rst_n is 0.
REQ-022 Requesters shall keep req_valid, req_entry and req_data stable until granted; the arbiter shall not buffer ungranted requests.
REQ-023 Latency shall be 1 cycle: after a transfer in cycle N, cycle N+1 shall show rob_data_ready=1, rob_commit_ready=1, rob_data_entry=req_entry of w, rob_data_out=req_data of w, and grant_id=w.
REQ-024 Sustained throughput shall be one transfer per cycle; back-to-back strobes shall be allowed.
REQ-025 In a cycle after no transfer, both strobes shall be 0; rob_data_entry, rob_data_out and grant_id shall hold their last values.
REQ-026 Flush asserted in cycle N shall block any grant in cycle N, force both strobes to 0 in cycle N+1, and leave rr_ptr unchanged.
REQ-027 A strobe already presented in cycle N, from a cycle N-1 grant, shall not be retracted by flush in cycle N.
REQ-028 Fairness: absent flush, a requester holding req_valid shall be granted within 4 cycles.
REQ-029 rob_data_ready and rob_commit_ready shall always be equal, so the ROB writes the value and sets the ready bit on the same edge.
REQ-030 Simultaneous requests targeting the same ROB entry shall be arbitrated normally, with no merging; preventing them is the issue logic's responsibility.

Reset
REQ-031 While rst_n=0 at posedge clk, the block shall clear rob_data_ready, rob_commit_ready, rob_data_entry, rob_data_out, grant_id and rr_ptr to 0.
REQ-032 rst_n=0 shall take priority over flush and over any pending request.
REQ-033 Reset asserted mid-stream shall discard the transfer of that cycle.
REQ-034 In the first cycle after rst_n returns to 1, strobes shall be 0 and arbitration shall start from requester 0.

Verification
REQ-035 Reset, then req_valid=4'b0001 with entry 5 and data 64'hA5 -> req_ready=4'b0001 that cycle; next cycle strobes=1, rob_data_entry=5, rob_data_out=64'hA5, grant_id=0.
REQ-036 req_valid=4'b1111 held 4 cycles after reset -> req_ready sequence 0001, 0010, 0100, 1000; strobes high 4 consecutive cycles.
REQ-037 rr_ptr=2 and req_valid=4'b0011 -> requester 0 granted first; rr_ptr becomes 1.
REQ-038 flush=1 with req_valid=4'b0110 -> req_ready=0; next cycle strobes=0; rr_ptr unchanged; the same request is granted in the first cycle after flush deasserts.
REQ-039 Transfer in cycle N, then flush in N+1 -> cycle N+1 strobe still 1; cycle N+2 strobe 0.
REQ-040 rst_n=0 during continuous 4'b1111 requests -> outputs 0 next cycle; after release, grant restarts at requester 0.
